tpu_instr_sequencer: RTL and testbench
======================================

Name: tpu_instr_sequencer

Overview:
- Sequences the 32-entry instruction buffer, which the UART DMA loads, into the datapath units: systolic array, VPU and unified buffer.
- After a start pulse it fetches instructions in order, decodes the opcode and waits until the target unit is idle. It then pulses that unit's start, waits for its done, and moves to the next instruction.
- It sits between the UART DMA (start_execution, status readback) and the datapath units.

Parameters:
- ADDR_W, 5, instruction buffer address width (depth 2^ADDR_W = 32)
- INSTR_W, 32, instruction width; opcode is [INSTR_W-1:INSTR_W-8], argument is the remaining low bits
- TIMEOUT_CYCLES, 65535, watchdog limit in cycles (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle pulse that begins execution at PC 0
- abort  in  1  level; returns to IDLE immediately
- instr_count  in  ADDR_W+1  number of valid instructions (0..32), sampled at start
- instr_rd_en  out  1  instruction buffer read strobe
- instr_rd_addr  out  ADDR_W  read address (= PC)
- instr_rd_data  in  INSTR_W  read data, valid exactly 1 cycle after instr_rd_en
- sys_start / vpu_start / ub_start  out  1 each  single-cycle issue pulses
- op_arg  out  INSTR_W-8  argument of the issued instruction; held until the next issue
- sys_busy / vpu_busy / ub_busy  in  1 each  unit busy
- sys_done / vpu_done / ub_done  in  1 each  unit completion pulse
- seq_busy  out  1  high from the cycle after start until FINISH or ERROR
- seq_done  out  1  single-cycle pulse on normal completion
- seq_error  out  2  0 = none, 1 = illegal opcode, 2 = aborted, 3 = timeout
- pc  out  ADDR_W  current PC
- debug_state  out  4  current state encoding

Behaviour:
- Reset: all outputs 0; state IDLE; pc 0; latched count 0.
- Opcodes:
  - 0x00 NOP: no issue; advance PC.
  - 0x01 SYS, 0x02 VPU, 0x03 UB: issue to that unit.
  - 0xFF HALT: go to FINISH.
  - Any other opcode: go to ERROR with seq_error = 1.
- States and transitions:
  - IDLE: on start, latch instr_count, set pc = 0, clear seq_error, raise seq_busy, go to FETCH. If the latched count is 0, go straight to FINISH.
  - FETCH: assert instr_rd_en with instr_rd_addr = pc for 1 cycle, go to WAIT_RD.
  - WAIT_RD: capture instr_rd_data into the instruction register, go to DECODE.
  - DECODE: act on the opcode as listed above; unit opcodes go to ISSUE.
  - ISSUE: hold while the target unit's busy is high. Once it is low, pulse that unit's start for 1 cycle, drive op_arg, go to WAIT_DONE.
  - WAIT_DONE: wait for the target unit's done. Done pulses from non-target units are ignored. A done in the same cycle as the start pulse is not accepted; acceptance begins the cycle after the issue.
  - NEXT: pc + 1. If pc + 1 equals the latched count, or pc was 31 (no wrap is permitted), go to FINISH; otherwise go to FETCH.
  - FINISH: pulse seq_done for 1 cycle, drop seq_busy, go to IDLE.
  - ERROR: drop seq_busy with no seq_done, hold seq_error, go to IDLE.
- Latency:
  - start to instr_rd_en: 1 cycle.
  - Fetch to issue with target idle: 3 cycles (FETCH, WAIT_RD, DECODE, then pulse in ISSUE).
  - Done to next FETCH: 2 cycles.
- start received while not in IDLE is ignored.
- abort:
  - Takes priority over all other inputs in any non-IDLE state: next state IDLE, seq_error = 2, seq_busy low, no seq_done.
  - A start in the same cycle as abort is ignored.
  - abort in IDLE has no effect.
- seq_error holds its value until the next accepted start.
- pc is driven to the buffer as-is; argument bits are passed through unmodified.

Optional Feature:
- Macro SEQ_WATCHDOG_EN.
- Defined: a cycle counter runs in ISSUE and WAIT_DONE and clears on every state entry. When it reaches TIMEOUT_CYCLES, go to ERROR with seq_error = 3.
- Not defined: no counter is instantiated; ISSUE and WAIT_DONE wait indefinitely; code 3 is never produced.

Decomposition:
- Shared package tpu_seq_pkg holds:
  - state enum;
  - opcode localparams: OP_NOP, OP_SYS, OP_VPU, OP_UB, OP_HALT;
  - error code localparams: ERR_NONE, ERR_ILLEGAL, ERR_ABORT, ERR_TIMEOUT.
- One natural sub-module, tpu_seq_unit_mux. It is combinational and maps the decoded target to the selected busy/done and the one-hot start vector.

Test Plan:
- Load [SYS 0x000010, VPU 0x000020, HALT], count = 3, units idle. Pulse start. Expected: sys_start with op_arg 0x000010, then after sys_done a vpu_start with 0x000020, then seq_done, pc = 2, seq_error = 0.
- Count = 2 with [UB, NOP]; ub_busy held high for 10 cycles. Expected: ub_start is delayed until busy falls, issues exactly once, then seq_done.
- Instruction 0x42000000 at PC 1. Expected: ERROR, seq_error = 1, no seq_done, no further instr_rd_en.
- abort while in WAIT_DONE on VPU. Expected: IDLE next cycle, seq_error = 2; a later vpu_done is ignored; a fresh start runs normally.
- Count = 32, all NOP. Expected: 32 reads at addresses 0..31, seq_done after PC 31, no wrap. Count = 0 gives seq_done 2 cycles after start with zero reads.
- With SEQ_WATCHDOG_EN and TIMEOUT_CYCLES = 100, a SYS instruction that never receives sys_done. Expected: seq_error = 3 exactly 100 cycles after entering WAIT_DONE.

Source files
------------

// File: rtl/tpu_seq_pkg.sv
// Shared definitions for the TPU instruction sequencer: state encodings, opcodes,
// error codes and unit selectors.
package tpu_seq_pkg;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_FETCH     = 4'd1;
    localparam logic [3:0] ST_WAIT_RD   = 4'd2;
    localparam logic [3:0] ST_DECODE    = 4'd3;
    localparam logic [3:0] ST_ISSUE     = 4'd4;
    localparam logic [3:0] ST_WAIT_DONE = 4'd5;
    localparam logic [3:0] ST_NEXT      = 4'd6;
    localparam logic [3:0] ST_FINISH    = 4'd7;
    localparam logic [3:0] ST_ERROR     = 4'd8;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_SYS  = 8'h01;
    localparam logic [7:0] OP_VPU  = 8'h02;
    localparam logic [7:0] OP_UB   = 8'h03;
    localparam logic [7:0] OP_HALT = 8'hFF;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_ABORT   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [1:0] UNIT_NONE = 2'd0;
    localparam logic [1:0] UNIT_SYS  = 2'd1;
    localparam logic [1:0] UNIT_VPU  = 2'd2;
    localparam logic [1:0] UNIT_UB   = 2'd3;

    function automatic logic [1:0] op_unit(input logic [7:0] op);
        case (op)
            OP_SYS:  op_unit = UNIT_SYS;
            OP_VPU:  op_unit = UNIT_VPU;
            OP_UB:   op_unit = UNIT_UB;
            default: op_unit = UNIT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/tpu_seq_unit_mux.sv
// Combinational unit selector: routes the target unit's busy/done back to the sequencer
// and fans the issue strobe out as a one-hot start vector.
module tpu_seq_unit_mux
    import tpu_seq_pkg::*;
(
    input  logic [1:0] target_i,
    input  logic       issue_i,
    input  logic [2:0] busy_i,    // {ub, vpu, sys}
    input  logic [2:0] done_i,    // {ub, vpu, sys}
    output logic       sel_busy_o,
    output logic       sel_done_o,
    output logic [2:0] start_o
);

    always_comb begin
        sel_busy_o = 1'b0;
        sel_done_o = 1'b0;
        start_o    = 3'b000;
        case (target_i)
            UNIT_SYS: begin
                sel_busy_o = busy_i[0];
                sel_done_o = done_i[0];
                start_o[0] = issue_i;
            end
            UNIT_VPU: begin
                sel_busy_o = busy_i[1];
                sel_done_o = done_i[1];
                start_o[1] = issue_i;
            end
            UNIT_UB: begin
                sel_busy_o = busy_i[2];
                sel_done_o = done_i[2];
                start_o[2] = issue_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/tpu_instr_sequencer.sv
// Fetches instructions from the buffer in order and issues them to the SYS/VPU/UB units.
// Define SEQ_WATCHDOG_EN to add a timeout on unit waits (error code 3).
module tpu_instr_sequencer
    import tpu_seq_pkg::*;
#(
    parameter int unsigned ADDR_W         = 5,
    parameter int unsigned INSTR_W        = 32,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [ADDR_W:0]    instr_count_i,
    output logic               instr_rd_en_o,
    output logic [ADDR_W-1:0]  instr_rd_addr_o,
    input  logic [INSTR_W-1:0] instr_rd_data_i,
    output logic               sys_start_o,
    output logic               vpu_start_o,
    output logic               ub_start_o,
    output logic [INSTR_W-9:0] op_arg_o,
    input  logic               sys_busy_i,
    input  logic               vpu_busy_i,
    input  logic               ub_busy_i,
    input  logic               sys_done_i,
    input  logic               vpu_done_i,
    input  logic               ub_done_i,
    output logic               seq_busy_o,
    output logic               seq_done_o,
    output logic [1:0]         seq_error_o,
    output logic [ADDR_W-1:0]  pc_o,
    output logic [3:0]         debug_state_o
);

    logic [3:0]         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [1:0]         target_q, target_d;
    logic [INSTR_W-9:0] op_arg_q, op_arg_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [1:0]         err_q, err_d;

    logic               sel_busy, sel_done, issue, timeout, waiting;
    logic [2:0]         unit_start;
    logic [7:0]         opcode;
    logic [ADDR_W:0]    pc_inc;

    assign opcode  = ir_q[INSTR_W-1 -: 8];
    assign pc_inc  = {1'b0, pc_q} + {{ADDR_W{1'b0}}, 1'b1};
    assign waiting = (state_q == ST_ISSUE) || (state_q == ST_WAIT_DONE);
    assign issue   = (state_q == ST_ISSUE) && !sel_busy && !abort_i && !timeout;

    tpu_seq_unit_mux u_unit_mux (
        .target_i   (target_q),
        .issue_i    (issue),
        .busy_i     ({ub_busy_i, vpu_busy_i, sys_busy_i}),
        .done_i     ({ub_done_i, vpu_done_i, sys_done_i}),
        .sel_busy_o (sel_busy),
        .sel_done_o (sel_done),
        .start_o    (unit_start)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        count_d  = count_q;
        ir_d     = ir_q;
        target_d = target_q;
        op_arg_d = op_arg_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        if (state_q != ST_IDLE && abort_i) begin
            state_d = ST_IDLE;
            err_d   = ERR_ABORT;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A start coinciding with abort is dropped.
                    if (start_i && !abort_i) begin
                        count_d = instr_count_i;
                        pc_d    = '0;
                        err_d   = ERR_NONE;
                        busy_d  = 1'b1;
                        state_d = (instr_count_i == '0) ? ST_FINISH : ST_FETCH;
                    end
                end
                ST_FETCH:   state_d = ST_WAIT_RD;
                ST_WAIT_RD: begin
                    ir_d    = instr_rd_data_i;
                    state_d = ST_DECODE;
                end
                ST_DECODE: begin
                    if (opcode == OP_NOP) begin
                        state_d = ST_NEXT;
                    end else if (opcode == OP_HALT) begin
                        state_d = ST_FINISH;
                    end else if (op_unit(opcode) != UNIT_NONE) begin
                        target_d = op_unit(opcode);
                        state_d  = ST_ISSUE;
                    end else begin
                        err_d   = ERR_ILLEGAL;
                        state_d = ST_ERROR;
                    end
                end
                ST_ISSUE: begin
                    if (timeout) begin
                        err_d   = ERR_TIMEOUT;
                        state_d = ST_ERROR;
                    end else if (issue) begin
                        op_arg_d = ir_q[INSTR_W-9:0];
                        state_d  = ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (timeout) begin
                        err_d   = ERR_TIMEOUT;
                        state_d = ST_ERROR;
                    end else if (sel_done) begin
                        state_d = ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    // The last buffer slot ends the program even if the count says otherwise.
                    if (pc_inc == count_q || &pc_q) begin
                        state_d = ST_FINISH;
                    end else begin
                        pc_d    = pc_inc[ADDR_W-1:0];
                        state_d = ST_FETCH;
                    end
                end
                ST_FINISH: begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
                ST_ERROR: begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

`ifdef SEQ_WATCHDOG_EN
    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WdW-1:0] wd_q, wd_d;

    assign timeout = waiting && (wd_q == WdW'(TIMEOUT_CYCLES - 1));

    // Restart on every state change so ISSUE and WAIT_DONE are each timed from entry.
    always_comb begin
        wd_d = '0;
        if (state_d == state_q && waiting) begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^{TIMEOUT_CYCLES, waiting};
    assign timeout            = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            count_q  <= '0;
            ir_q     <= '0;
            target_q <= UNIT_NONE;
            op_arg_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= ERR_NONE;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            ir_q     <= ir_d;
            target_q <= target_d;
            op_arg_q <= op_arg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign instr_rd_en_o   = (state_q == ST_FETCH);
    assign instr_rd_addr_o = pc_q;
    assign sys_start_o     = unit_start[0];
    assign vpu_start_o     = unit_start[1];
    assign ub_start_o      = unit_start[2];
    assign op_arg_o        = issue ? ir_q[INSTR_W-9:0] : op_arg_q;
    assign seq_busy_o      = busy_q;
    assign seq_done_o      = done_q;
    assign seq_error_o     = err_q;
    assign pc_o            = pc_q;
    assign debug_state_o   = state_q;

endmodule

// File: tb/tb_tpu_instr_sequencer.sv
// Self-checking bench for tpu_instr_sequencer: table of whole-program runs plus
// hand-written latency, busy-stall, abort and watchdog sequences.
module tb_tpu_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort;
    logic [5:0]  instr_count;
    logic        instr_rd_en;
    logic [4:0]  instr_rd_addr;
    logic [31:0] instr_rd_data = '0;
    logic        sys_start, vpu_start, ub_start;
    logic [23:0] op_arg;
    logic        sys_busy, vpu_busy, ub_busy;
    logic        sys_done, vpu_done, ub_done;
    logic        seq_busy, seq_done;
    logic [1:0]  seq_error;
    logic [4:0]  pc;
    logic [3:0]  debug_state;

    always #5 clk = ~clk;

    tpu_instr_sequencer #(
        .ADDR_W         (5),
        .INSTR_W        (32),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (start),
        .abort_i         (abort),
        .instr_count_i   (instr_count),
        .instr_rd_en_o   (instr_rd_en),
        .instr_rd_addr_o (instr_rd_addr),
        .instr_rd_data_i (instr_rd_data),
        .sys_start_o     (sys_start),
        .vpu_start_o     (vpu_start),
        .ub_start_o      (ub_start),
        .op_arg_o        (op_arg),
        .sys_busy_i      (sys_busy),
        .vpu_busy_i      (vpu_busy),
        .ub_busy_i       (ub_busy),
        .sys_done_i      (sys_done),
        .vpu_done_i      (vpu_done),
        .ub_done_i       (ub_done),
        .seq_busy_o      (seq_busy),
        .seq_done_o      (seq_done),
        .seq_error_o     (seq_error),
        .pc_o            (pc),
        .debug_state_o   (debug_state)
    );

    // Instruction buffer: data valid the cycle after the read strobe.
    logic [31:0] mem [32];
    always @(posedge clk) if (instr_rd_en) instr_rd_data <= mem[instr_rd_addr];

    // Unit models: busy for 3 cycles after start, optional auto done pulse at the end.
    logic [2:0] unit_start, force_busy, man_done, auto_en;
    logic [2:0] auto_done = '0;
    int         lat_cnt [3] = '{default: 0};
    assign unit_start = {ub_start, vpu_start, sys_start};
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            auto_done[i] <= 1'b0;
            if (unit_start[i]) begin
                lat_cnt[i] <= 3;
            end else if (lat_cnt[i] > 0) begin
                lat_cnt[i] <= lat_cnt[i] - 1;
                if (lat_cnt[i] == 1 && auto_en[i]) auto_done[i] <= 1'b1;
            end
        end
    end
    assign sys_busy = force_busy[0] | (lat_cnt[0] != 0);
    assign vpu_busy = force_busy[1] | (lat_cnt[1] != 0);
    assign ub_busy  = force_busy[2] | (lat_cnt[2] != 0);
    assign sys_done = auto_done[0] | man_done[0];
    assign vpu_done = auto_done[1] | man_done[1];
    assign ub_done  = auto_done[2] | man_done[2];

    // Event monitor
    int   n_reads, n_sys, n_vpu, n_ub, n_done, arg_sum;
    logic addr_ok;
    always @(negedge clk) begin
        if (rst_n) begin
            if (instr_rd_en) begin
                if (instr_rd_addr != n_reads[4:0]) addr_ok = 1'b0;
                n_reads++;
            end
            if (sys_start) begin n_sys++; arg_sum += int'(op_arg); end
            if (vpu_start) begin n_vpu++; arg_sum += int'(op_arg); end
            if (ub_start)  begin n_ub++;  arg_sum += int'(op_arg); end
            if (seq_done) n_done++;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        n_reads = 0; n_sys = 0; n_vpu = 0; n_ub = 0; n_done = 0; arg_sum = 0;
        addr_ok = 1'b1;
    endtask

    task automatic run_prog(input logic [5:0] cnt);
        @(posedge clk); #1;
        clear_counts();
        instr_count = cnt;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        @(negedge clk);
        while (debug_state != 4'd0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) begin
            total++; bad++;
            $display("FAIL %s_idle_timeout: state 0x%0h after %0d cycles, want 0", name,
                     debug_state, k);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_pulse(input string name, input int unit);
        int k = 0;
        while (!unit_start[unit] && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) begin
            total++; bad++;
            $display("FAIL %s_no_start: unit %0d never started, want a start", name, unit);
        end
    endtask

    task automatic load(input logic [31:0] p0, input logic [31:0] p1,
                        input logic [31:0] p2, input logic [31:0] p3);
        for (int a = 0; a < 32; a++) mem[a] = 32'h0;
        mem[0] = p0; mem[1] = p1; mem[2] = p2; mem[3] = p3;
    endtask

    typedef struct {
        logic [31:0] p0, p1, p2, p3;
        logic [5:0]  cnt;
        int          reads, sys, vpu, ub, done, err, pc, argsum;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] p0, input logic [31:0] p1,
                                input logic [31:0] p2, input logic [31:0] p3,
                                input logic [5:0] cnt, input int reads, input int sys,
                                input int vpu, input int ub, input int done, input int err,
                                input int pcv, input int argsum);
        vec_t v;
        v.p0 = p0; v.p1 = p1; v.p2 = p2; v.p3 = p3; v.cnt = cnt;
        v.reads = reads; v.sys = sys; v.vpu = vpu; v.ub = ub; v.done = done;
        v.err = err; v.pc = pcv; v.argsum = argsum;
        return v;
    endfunction

    vec_t vecs [7];

    initial begin
        vecs[0] = mk(32'h01000010, 32'h02000020, 32'hFF000000, 32'h0, 6'd3,
                     3, 1, 1, 0, 1, 0, 2, 'h30);
        vecs[1] = mk(32'h00000000, 32'h42000000, 32'h01000001, 32'h0, 6'd3,
                     2, 0, 0, 0, 0, 1, 1, 0);
        vecs[2] = mk(32'h03000005, 32'h00000000, 32'h0, 32'h0, 6'd2,
                     2, 0, 0, 1, 1, 0, 1, 5);
        vecs[3] = mk(32'h0, 32'h0, 32'h0, 32'h0, 6'd0,
                     0, 0, 0, 0, 1, 0, 0, 0);
        vecs[4] = mk(32'h0, 32'h0, 32'h0, 32'h0, 6'd32,
                     32, 0, 0, 0, 1, 0, 31, 0);
        vecs[5] = mk(32'h01000001, 32'h01000002, 32'h03000003, 32'h02000004, 6'd4,
                     4, 2, 1, 1, 1, 0, 3, 10);
        vecs[6] = mk(32'h0, 32'h0, 32'h0, 32'h0, 6'd40,
                     32, 0, 0, 0, 1, 0, 31, 0);

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; instr_count = '0;
        force_busy = '0; man_done = '0; auto_en = 3'b111;
        clear_counts();
        load(32'h0, 32'h0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        check("rst_outputs",
              {instr_rd_en, instr_rd_addr, sys_start, vpu_start, ub_start, op_arg,
               seq_busy, seq_done, seq_error, pc, debug_state}, 64'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_state", {60'h0, debug_state}, 64'h0);

        for (int r = 0; r < 7; r++) begin
            load(vecs[r].p0, vecs[r].p1, vecs[r].p2, vecs[r].p3);
            run_prog(vecs[r].cnt);
            wait_idle($sformatf("v%0d", r));
            check($sformatf("v%0d_reads", r),   64'(n_reads), 64'(vecs[r].reads));
            check($sformatf("v%0d_addr_ok", r), 64'(addr_ok), 64'h1);
            check($sformatf("v%0d_sys", r),     64'(n_sys),   64'(vecs[r].sys));
            check($sformatf("v%0d_vpu", r),     64'(n_vpu),   64'(vecs[r].vpu));
            check($sformatf("v%0d_ub", r),      64'(n_ub),    64'(vecs[r].ub));
            check($sformatf("v%0d_done", r),    64'(n_done),  64'(vecs[r].done));
            check($sformatf("v%0d_err", r),     64'(seq_error), 64'(vecs[r].err));
            check($sformatf("v%0d_pc", r),      64'(pc),      64'(vecs[r].pc));
            check($sformatf("v%0d_argsum", r),  64'(arg_sum), 64'(vecs[r].argsum));
            check($sformatf("v%0d_busy_low", r), 64'(seq_busy), 64'h0);
        end

        // Latency: start -> read 1 cycle, fetch -> issue 3 cycles, done -> fetch 2 cycles.
        load(32'h01000010, 32'hFF000000, 32'h0, 32'h0);
        run_prog(6'd2);
        @(negedge clk);
        check("lat_rd_en_c1", 64'(instr_rd_en), 64'h1);
        check("lat_busy_c1",  64'(seq_busy),    64'h1);
        @(negedge clk);
        check("lat_rd_en_c2", 64'(instr_rd_en), 64'h0);
        @(negedge clk);
        check("lat_no_issue_c3", 64'(sys_start), 64'h0);
        @(negedge clk);
        check("lat_issue_c4", 64'(sys_start), 64'h1);
        check("lat_arg_c4",   64'(op_arg),    64'h10);
        @(negedge clk);
        check("lat_pulse_len", 64'(sys_start), 64'h0);
        check("lat_arg_held",  64'(op_arg),    64'h10);
        begin
            int k = 0;
            while (!sys_done && k < 50) begin @(negedge clk); k++; end
        end
        check("lat_saw_done", 64'(sys_done), 64'h1);
        @(negedge clk);
        check("lat_done_plus1", 64'(instr_rd_en), 64'h0);
        @(negedge clk);
        check("lat_done_plus2", 64'(instr_rd_en), 64'h1);
        check("lat_addr1",      64'(instr_rd_addr), 64'h1);
        wait_idle("lat");
        check("lat_seq_done", 64'(n_done), 64'h1);

        // UB held busy: issue waits, restart while running is ignored.
        load(32'h03000007, 32'h0, 32'h0, 32'h0);
        force_busy[2] = 1'b1;
        run_prog(6'd2);
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(negedge clk);
        check("busy_no_issue", 64'(n_ub),        64'h0);
        check("busy_in_issue", 64'(debug_state), 64'h4);
        check("busy_one_read", 64'(n_reads),     64'h1);
        force_busy[2] = 1'b0;
        wait_idle("busy");
        check("busy_ub_once", 64'(n_ub),    64'h1);
        check("busy_arg",     64'(arg_sum), 64'h7);
        check("busy_done",    64'(n_done),  64'h1);

        // Abort while waiting for VPU done.
        load(32'h02000009, 32'hFF000000, 32'h0, 32'h0);
        auto_en[1] = 1'b0;
        run_prog(6'd2);
        wait_pulse("abort", 1);
        @(negedge clk);
        check("abort_in_wait", 64'(debug_state), 64'h5);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle",  64'(debug_state), 64'h0);
        check("abort_err",   64'(seq_error),   64'h2);
        check("abort_busy",  64'(seq_busy),    64'h0);
        repeat (3) @(negedge clk);
        man_done[1] = 1'b1;
        @(negedge clk);
        man_done[1] = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_stay_idle", 64'(debug_state), 64'h0);
        check("abort_no_done",   64'(n_done),      64'h0);
        check("abort_reads",     64'(n_reads),     64'h1);
        check("abort_err_held",  64'(seq_error),   64'h2);
        auto_en[1] = 1'b1;
        run_prog(6'd2);
        wait_idle("abort_rerun");
        check("rerun_done", 64'(n_done),    64'h1);
        check("rerun_err",  64'(seq_error), 64'h0);
        check("rerun_vpu",  64'(n_vpu),     64'h1);

        // SYS that never completes.
        load(32'h01000003, 32'h0, 32'h0, 32'h0);
        auto_en[0] = 1'b0;
        run_prog(6'd1);
        wait_pulse("wd", 0);
`ifdef SEQ_WATCHDOG_EN
        repeat (100) @(negedge clk);
        check("wd_before_err",   64'(seq_error),   64'h0);
        check("wd_before_state", 64'(debug_state), 64'h5);
        @(negedge clk);
        check("wd_err",   64'(seq_error),   64'h3);
        check("wd_state", 64'(debug_state), 64'h8);
        wait_idle("wd");
        check("wd_no_done", 64'(n_done), 64'h0);
`else
        repeat (300) @(negedge clk);
        check("nowd_still_wait", 64'(debug_state), 64'h5);
        check("nowd_err",        64'(seq_error),   64'h0);
        man_done[0] = 1'b1;
        @(negedge clk);
        man_done[0] = 1'b0;
        wait_idle("nowd");
        check("nowd_done", 64'(n_done), 64'h1);
`endif
        auto_en[0] = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
